// File: rtl/dds_key_sweep_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : dds_key_sweep_ctrl_if
// Brief    : Front-panel key inputs and dds_ctrl configuration outputs.
// Revision : 1.0 - initial release
// ============================================================================
interface dds_key_sweep_ctrl_if;
    logic       key_wave;
    logic       key_sel;
    logic       key_up;
    logic       key_down;
    logic       key_sweep;
    logic [1:0] waveform_counter;
    logic [4:0] freq_counter;
    logic [4:0] freq_counter2;
    logic       edit_sel;
    logic       sweep_active;
    logic       cfg_update;

    // Panel / stimulus side: drives the raw keys, observes the configuration.
    modport master (
        output key_wave, key_sel, key_up, key_down, key_sweep,
        input  waveform_counter, freq_counter, freq_counter2,
        input  edit_sel, sweep_active, cfg_update
    );

    // Controller side.
    modport slave (
        input  key_wave, key_sel, key_up, key_down, key_sweep,
        output waveform_counter, freq_counter, freq_counter2,
        output edit_sel, sweep_active, cfg_update
    );
endinterface
`default_nettype wire

// File: rtl/dds_key_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dds_key_sweep_ctrl
// Brief    : Debounces five panel keys and drives the dds_ctrl configuration,
//            with manual step editing and a triangular freq_counter sweep.
// Revision : 1.0 - initial release
// ============================================================================
module dds_key_sweep_ctrl #(
    parameter int unsigned DEBOUNCE_CNT = 1_000_000,
    parameter int unsigned SWEEP_DWELL  = 5_000_000,
    parameter logic [4:0]  FREQ_MAX     = 5'd31
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    dds_key_sweep_ctrl_if.slave  bus
);

    localparam int unsigned c_NKEYS   = 5;
    localparam int unsigned c_K_WAVE  = 0;
    localparam int unsigned c_K_SEL   = 1;
    localparam int unsigned c_K_UP    = 2;
    localparam int unsigned c_K_DOWN  = 3;
    localparam int unsigned c_K_SWEEP = 4;

    localparam int unsigned c_DB_W = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
    localparam int unsigned c_DW_W = (SWEEP_DWELL  > 1) ? $clog2(SWEEP_DWELL)  : 1;
    localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE_CNT - 1);
    localparam logic [c_DW_W-1:0] c_DW_LAST = c_DW_W'(SWEEP_DWELL - 1);

    typedef enum logic [1:0] {
        ST_MANUAL   = 2'd0,
        ST_SWEEP_UP = 2'd1,
        ST_SWEEP_DN = 2'd2
    } state_t;

    logic [c_NKEYS-1:0] w_key_raw;
    logic [c_NKEYS-1:0] w_press;

    assign w_key_raw = {bus.key_sweep, bus.key_down, bus.key_up, bus.key_sel, bus.key_wave};

    // Keys are active-low: a press is the stable level falling from 1 to 0.
    generate
        for (genvar gi = 0; gi < c_NKEYS; gi++) begin : g_key
            logic              r_sync1;
            logic              r_sync2;
            logic              r_stable;
            logic              r_stable_d;
            logic [c_DB_W-1:0] r_cnt;

            always_ff @(posedge sys_clk or posedge sys_rst) begin
                if (sys_rst) begin
                    r_sync1    <= 1'b1;
                    r_sync2    <= 1'b1;
                    r_stable   <= 1'b1;
                    r_stable_d <= 1'b1;
                    r_cnt      <= '0;
                end else begin
                    r_sync1    <= w_key_raw[gi];
                    r_sync2    <= r_sync1;
                    r_stable_d <= r_stable;
                    if (r_sync2 != r_stable) begin
                        if (r_cnt == c_DB_LAST) begin
                            r_stable <= r_sync2;
                            r_cnt    <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else begin
                        r_cnt <= '0;
                    end
                end
            end

            assign w_press[gi] = r_stable_d & ~r_stable;
        end
    endgenerate

    state_t            r_state;
    state_t            w_state_nxt;
    logic [c_DW_W-1:0] r_dwell;
    logic [c_DW_W-1:0] w_dwell_nxt;
    logic [1:0]        r_wave;
    logic [1:0]        w_wave_nxt;
    logic [4:0]        r_freq;
    logic [4:0]        w_freq_nxt;
    logic [4:0]        r_freq2;
    logic [4:0]        w_freq2_nxt;
    logic              r_edit_sel;
    logic              w_sel_nxt;
    logic              r_sweep_active;
    logic              r_cfg_chg;
    logic              r_cfg_update;
    logic              w_up_only;
    logic              w_dn_only;

    assign w_up_only = w_press[c_K_UP]   & ~w_press[c_K_DOWN];
    assign w_dn_only = w_press[c_K_DOWN] & ~w_press[c_K_UP];

    always_comb begin
        w_state_nxt = r_state;
        w_dwell_nxt = r_dwell;
        w_wave_nxt  = r_wave;
        w_freq_nxt  = r_freq;
        w_freq2_nxt = r_freq2;
        w_sel_nxt   = r_edit_sel;

        if (w_press[c_K_WAVE]) begin
            w_wave_nxt = r_wave + 2'd1;
        end

        case (r_state)
            ST_MANUAL: begin
                if (w_press[c_K_SEL]) begin
                    w_sel_nxt = ~r_edit_sel;
                end
                if (w_up_only) begin
                    if (!r_edit_sel && r_freq < FREQ_MAX) begin
                        w_freq_nxt = r_freq + 5'd1;
                    end else if (r_edit_sel && r_freq2 < FREQ_MAX) begin
                        w_freq2_nxt = r_freq2 + 5'd1;
                    end
                end
                if (w_dn_only) begin
                    if (!r_edit_sel && r_freq != 5'd0) begin
                        w_freq_nxt = r_freq - 5'd1;
                    end else if (r_edit_sel && r_freq2 != 5'd0) begin
                        w_freq2_nxt = r_freq2 - 5'd1;
                    end
                end
                if (w_press[c_K_SWEEP]) begin
                    w_state_nxt = ST_SWEEP_UP;
                    w_dwell_nxt = '0;
                end
            end
            ST_SWEEP_UP, ST_SWEEP_DN: begin
                // Exit takes priority over a step falling on the same cycle.
                if (w_press[c_K_SWEEP]) begin
                    w_state_nxt = ST_MANUAL;
                    w_dwell_nxt = '0;
                end else if (r_dwell == c_DW_LAST) begin
                    w_dwell_nxt = '0;
                    if (r_state == ST_SWEEP_UP) begin
                        if (r_freq >= FREQ_MAX) begin
                            w_state_nxt = ST_SWEEP_DN;
                            w_freq_nxt  = r_freq - 5'd1;
                        end else begin
                            w_freq_nxt  = r_freq + 5'd1;
                        end
                    end else begin
                        if (r_freq == 5'd0) begin
                            w_state_nxt = ST_SWEEP_UP;
                            w_freq_nxt  = r_freq + 5'd1;
                        end else begin
                            w_freq_nxt  = r_freq - 5'd1;
                        end
                    end
                end else begin
                    w_dwell_nxt = r_dwell + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_MANUAL;
                w_dwell_nxt = '0;
            end
        endcase
    end

    // cfg_update tracks only the three words consumed by dds_ctrl; edit_sel is panel-local.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state        <= ST_MANUAL;
            r_dwell        <= '0;
            r_wave         <= 2'd0;
            r_freq         <= 5'd0;
            r_freq2        <= 5'd0;
            r_edit_sel     <= 1'b0;
            r_sweep_active <= 1'b0;
            r_cfg_chg      <= 1'b0;
            r_cfg_update   <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_dwell        <= w_dwell_nxt;
            r_wave         <= w_wave_nxt;
            r_freq         <= w_freq_nxt;
            r_freq2        <= w_freq2_nxt;
            r_edit_sel     <= w_sel_nxt;
            r_sweep_active <= (w_state_nxt != ST_MANUAL);
            r_cfg_chg      <= (w_wave_nxt  != r_wave)  ||
                              (w_freq_nxt  != r_freq)  ||
                              (w_freq2_nxt != r_freq2);
            r_cfg_update   <= r_cfg_chg;
        end
    end

    assign bus.waveform_counter = r_wave;
    assign bus.freq_counter     = r_freq;
    assign bus.freq_counter2    = r_freq2;
    assign bus.edit_sel         = r_edit_sel;
    assign bus.sweep_active     = r_sweep_active;
    assign bus.cfg_update       = r_cfg_update;

endmodule
`default_nettype wire

// File: tb/tb_dds_key_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dds_key_sweep_ctrl
// Brief    : Scoreboard bench for dds_key_sweep_ctrl with a time-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dds_key_sweep_ctrl;

    localparam int DB   = 4;
    localparam int DW   = 8;
    localparam int FMAX = 31;

    localparam logic [4:0] K_WAVE  = 5'b00001;
    localparam logic [4:0] K_SEL   = 5'b00010;
    localparam logic [4:0] K_UP    = 5'b00100;
    localparam logic [4:0] K_DOWN  = 5'b01000;
    localparam logic [4:0] K_SWEEP = 5'b10000;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;

    dds_key_sweep_ctrl_if bus ();

    dds_key_sweep_ctrl #(
        .DEBOUNCE_CNT (DB),
        .SWEEP_DWELL  (DW),
        .FREQ_MAX     (5'd31)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int          e;
        logic [14:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   edge_cnt;

    // Behavioural model: keys accepted after DB consecutive samples, effect
    // lands a fixed number of edges later; sweep steps are timed by edge number.
    int m_e;
    int m_acc[5];
    int m_run[5];
    int m_pend[8];
    int m_wave, m_freq, m_freq2, m_sel, m_sweep, m_dir_up, m_next, m_chg;

    function automatic logic [14:0] dut_vec();
        return {bus.waveform_counter, bus.freq_counter, bus.freq_counter2,
                bus.edit_sel, bus.sweep_active, bus.cfg_update};
    endfunction

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    task automatic model_reset();
        m_e = 0;
        for (int i = 0; i < 5; i++) begin
            m_acc[i] = 1;
            m_run[i] = 0;
        end
        for (int i = 0; i < 8; i++) m_pend[i] = 0;
        m_wave = 0; m_freq = 0; m_freq2 = 0; m_sel = 0;
        m_sweep = 0; m_dir_up = 1; m_next = 0; m_chg = 0;
    endtask

    task automatic drive_keys(input logic [4:0] raw);
        bus.key_wave  = raw[0];
        bus.key_sel   = raw[1];
        bus.key_up    = raw[2];
        bus.key_down  = raw[3];
        bus.key_sweep = raw[4];
    endtask

    // Called at a falling edge: applies keys for the next rising edge,
    // predicts the outputs after it, then waits for the following falling edge.
    task automatic step(input logic [4:0] held);
        logic [4:0]  raw;
        int          pr;
        int          old_w, old_f, old_f2, cfg;
        logic [14:0] v;
        raw = ~held;
        drive_keys(raw);
        m_e++;
        for (int i = 0; i < 5; i++) begin
            if (int'(raw[i]) != m_acc[i]) begin
                m_run[i]++;
                if (m_run[i] == DB) begin
                    m_acc[i] = int'(raw[i]);
                    m_run[i] = 0;
                    if (raw[i] == 1'b0) m_pend[(m_e + 3) % 8] |= (1 << i);
                end
            end else begin
                m_run[i] = 0;
            end
        end
        pr = m_pend[m_e % 8];
        m_pend[m_e % 8] = 0;
        old_w = m_wave; old_f = m_freq; old_f2 = m_freq2;

        if (pr & 1) m_wave = (m_wave + 1) % 4;
        if (m_sweep == 0) begin
            if (pr & 2) m_sel = 1 - m_sel;
            if ((pr & 4) && !(pr & 8)) begin
                if (m_sel == 0) m_freq  = (m_freq  < FMAX) ? m_freq  + 1 : FMAX;
                else            m_freq2 = (m_freq2 < FMAX) ? m_freq2 + 1 : FMAX;
            end
            if ((pr & 8) && !(pr & 4)) begin
                if (m_sel == 0) m_freq  = (m_freq  > 0) ? m_freq  - 1 : 0;
                else            m_freq2 = (m_freq2 > 0) ? m_freq2 - 1 : 0;
            end
            if (pr & 16) begin
                m_sweep = 1; m_dir_up = 1; m_next = m_e + DW;
            end
        end else begin
            if (pr & 16) begin
                m_sweep = 0;
            end else if (m_e == m_next) begin
                m_next = m_next + DW;
                if (m_dir_up == 1) begin
                    if (m_freq == FMAX) begin m_dir_up = 0; m_freq = m_freq - 1; end
                    else m_freq = m_freq + 1;
                end else begin
                    if (m_freq == 0) begin m_dir_up = 1; m_freq = m_freq + 1; end
                    else m_freq = m_freq - 1;
                end
            end
        end

        cfg   = m_chg;
        m_chg = (old_w != m_wave || old_f != m_freq || old_f2 != m_freq2) ? 1 : 0;
        v = {m_wave[1:0], m_freq[4:0], m_freq2[4:0], m_sel[0], m_sweep[0], cfg[0]};
        exp_q.push_back('{e: m_e, v: v});
        @(negedge sys_clk);
    endtask

    task automatic press(input logic [4:0] m, input int len, input int gap);
        repeat (len) step(m);
        repeat (gap) step(5'b0);
    endtask

    task automatic set_freq(input int target);
        int guard = 0;
        while (m_freq != target && guard < 40) begin
            if (m_freq < target) press(K_UP, 5, 6);
            else                 press(K_DOWN, 5, 6);
            guard++;
        end
        check("set_freq_reached", m_freq, target);
    endtask

    always @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) edge_cnt <= 0;
        else         edge_cnt <= edge_cnt + 1;
    end

    always @(negedge sys_clk) begin
        exp_t x;
        if (!sys_rst) begin
            while (exp_q.size() > 0 && exp_q[0].e <= edge_cnt) begin
                x = exp_q.pop_front();
                check($sformatf("outputs@edge%0d", x.e), int'(dut_vec()), int'(x.v));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        int op;
        drive_keys(5'b11111);
        model_reset();
        repeat (3) @(negedge sys_clk);
        check("reset_outputs", int'(dut_vec()), 0);
        sys_rst = 1'b0;

        // Idle: everything stays zero, no cfg_update.
        repeat (12) step(5'b0);

        // Glitch shorter than the debounce window, then a real press.
        press(K_UP, 3, 8);
        press(K_UP, 10, 10);

        // Waveform wrap, then edit freq_counter2.
        repeat (4) press(K_WAVE, 5, 6);
        press(K_SEL, 5, 6);
        repeat (2) press(K_UP, 5, 6);

        // Saturation at both ends of freq_counter.
        press(K_SEL, 5, 6);
        set_freq(31);
        press(K_UP, 5, 8);
        set_freq(0);
        press(K_DOWN, 5, 8);

        // Simultaneous up/down, then a triangular sweep from 29.
        set_freq(29);
        press(K_UP | K_DOWN, 5, 8);
        press(K_SWEEP, 5, 6);
        repeat (60) step(5'b0);

        // Time a sweep press to land on a dwell wrap: exit must win.
        guard = 0;
        while (m_e + 1 != m_next - DB - 2 && guard < 100) begin
            step(5'b0);
            guard++;
        end
        check("exit_alignment_found", (guard < 100) ? 1 : 0, 1);
        press(K_SWEEP, 5, 6);
        repeat (12) step(5'b0);
        press(K_UP, 5, 8);

        // Randomised key activity.
        for (int n = 0; n < 80; n++) begin
            op = $urandom_range(0, 9);
            case (op)
                0, 1:    press(K_WAVE, $urandom_range(4, 9), $urandom_range(6, 12));
                2:       press(K_SEL, $urandom_range(4, 9), $urandom_range(6, 12));
                3:       press(K_UP, $urandom_range(4, 9), $urandom_range(6, 12));
                4:       press(K_DOWN, $urandom_range(4, 9), $urandom_range(6, 12));
                5:       press(K_UP | K_DOWN, $urandom_range(4, 9), $urandom_range(6, 12));
                6:       press(K_SWEEP, $urandom_range(4, 9), $urandom_range(6, 12));
                7:       press(5'b1 << $urandom_range(0, 4), $urandom_range(1, DB - 1),
                               $urandom_range(6, 12));
                default: repeat ($urandom_range(5, 40)) step(5'b0);
            endcase
        end

        // Asynchronous reset in the middle of a sweep.
        if (m_sweep == 0) press(K_SWEEP, 5, 6);
        repeat (20) step(5'b0);
        check("sweeping_before_reset", int'(bus.sweep_active), 1);
        @(posedge sys_clk);
        #2;
        sys_rst = 1'b1;
        #1;
        check("async_reset_outputs", int'(dut_vec()), 0);
        exp_q.delete();
        repeat (2) @(negedge sys_clk);
        check("outputs_held_in_reset", int'(dut_vec()), 0);
        sys_rst = 1'b0;
        model_reset();
        repeat (20) step(5'b0);
        press(K_UP, 5, 8);
        press(K_SWEEP, 5, 6);
        repeat (20) step(5'b0);

        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
